// File: rtl/cursor_pkg.sv
// Shared types and helpers for the cursor controller: movement FSM states,
// button index map and the coordinate clamp.
package cursor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } move_state_t;

    localparam int unsigned DIR_UP    = 0;
    localparam int unsigned DIR_DOWN  = 1;
    localparam int unsigned DIR_LEFT  = 2;
    localparam int unsigned DIR_RIGHT = 3;

    // Signed 12-bit keeps a step below zero negative instead of wrapping.
    typedef logic signed [11:0] coord_t;

    function automatic coord_t clamp(input coord_t v, input coord_t lo, input coord_t hi);
        coord_t r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-bit two-flop synchroniser for asynchronous button inputs; both
// stages load RST_VAL on reset so buttons read as released.
module btn_sync #(
    parameter int unsigned           WIDTH   = 4,
    parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cursor_ctrl.sv
// On-screen cursor controller: synchronised buttons drive a tick-paced
// press/auto-repeat FSM that moves a clamped cursor, plus a registered hit test.
module cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned CURSOR_SIZE  = 10,
    parameter int unsigned STEP         = 10,
    parameter int unsigned TICK_DIV     = 2000000,
    parameter int unsigned REPEAT_DELAY = 3,
    parameter int unsigned X_INIT       = 120,
    parameter int unsigned Y_INIT       = 40,
    parameter int unsigned CURSOR_COLOR = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic [8:0] row,
    input  logic [9:0] col,
    output logic       cursor_here,
    output logic [7:0] color_index,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       moved
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned HW = $clog2(REPEAT_DELAY + 1);

    logic [3:0] btn_raw;
    logic [3:0] btn_q;
    logic [3:0] held;

    logic signed [1:0] dx, dy;
    logic signed [1:0] last_dx, last_dy;
    logic              active;
    logic              dir_changed;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    move_state_t   state, state_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic          do_move;

    coord_t     x_mv, y_mv;
    logic [9:0] x_next;
    logic [8:0] y_next;
    logic       hit;

    // Bit order follows the DIR_* indices.
    assign btn_raw = {right, left, down, up};

    btn_sync #(
        .WIDTH   (4),
        .RST_VAL (4'b1111)
    ) u_btn_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_q)
    );

    assign held = ~btn_q;

    always_comb begin
        dx = 2'sd0;
        dy = 2'sd0;
        if (held[DIR_RIGHT] && !held[DIR_LEFT]) dx = 2'sd1;
        if (held[DIR_LEFT]  && !held[DIR_RIGHT]) dx = -2'sd1;
        if (held[DIR_DOWN]  && !held[DIR_UP])    dy = 2'sd1;
        if (held[DIR_UP]    && !held[DIR_DOWN])  dy = -2'sd1;
    end

    assign active      = (dx != 2'sd0) || (dy != 2'sd0);
    assign dir_changed = (dx != last_dx) || (dy != last_dy);

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        do_move = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (active) begin
                        do_move = 1'b1;
                        hold_n  = '0;
                        state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (!active) begin
                        state_n = IDLE;
                    end else if (dir_changed) begin
                        do_move = 1'b1;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                        if (hold_n == HW'(REPEAT_DELAY)) begin
                            do_move = 1'b1;
                            state_n = REPEAT;
                        end
                    end
                end
                REPEAT: begin
                    if (!active) begin
                        state_n = IDLE;
                    end else if (dir_changed) begin
                        do_move = 1'b1;
                        hold_n  = '0;
                        state_n = HOLD;
                    end else begin
                        do_move = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        x_mv = clamp($signed({2'b00, x}) + coord_t'(dx) * coord_t'(STEP),
                     coord_t'(0), coord_t'(SCREEN_W - CURSOR_SIZE));
        y_mv = clamp($signed({3'b000, y}) + coord_t'(dy) * coord_t'(STEP),
                     coord_t'(0), coord_t'(SCREEN_H - CURSOR_SIZE));
        x_next = x_mv[9:0];
        y_next = y_mv[8:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x       <= 10'(X_INIT);
            y       <= 9'(Y_INIT);
            moved   <= 1'b0;
            last_dx <= 2'sd0;
            last_dy <= 2'sd0;
        end else begin
            moved <= 1'b0;
            if (do_move) begin
                x       <= x_next;
                y       <= y_next;
                last_dx <= dx;
                last_dy <= dy;
                moved   <= (x_next != x) || (y_next != y);
            end
        end
    end

    assign hit = ({1'b0, col} >= {1'b0, x}) &&
                 ({1'b0, col} <  {1'b0, x} + 11'(CURSOR_SIZE)) &&
                 ({2'b00, row} >= {2'b00, y}) &&
                 ({2'b00, row} <  {2'b00, y} + 11'(CURSOR_SIZE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursor_here <= 1'b0;
            color_index <= '0;
        end else begin
            cursor_here <= hit;
            color_index <= hit ? 8'(CURSOR_COLOR) : '0;
        end
    end

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Parametrised on-screen cursor controller for the VGA game display. It synchronises the four active-low push-buttons and moves the cursor position once per movement tick, with press-then-auto-repeat behaviour and diagonal moves. Position is clamped to the visible area. Each cycle it reports whether the current scan pixel (`row`, `col`) lies inside the cursor square, and if so supplies the cursor palette index to the pixel mux.

## Interface

Parameters:
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height in pixels.
- `CURSOR_SIZE`, 10: cursor square side in pixels.
- `STEP`, 10: pixels moved per move event.
- `TICK_DIV`, 2000000: clk cycles per movement tick; must be ≥ 2.
- `REPEAT_DELAY`, 3: number of ticks a button must be held after the first move before auto-repeat starts; must be ≥ 1.
- `X_INIT`, 120: reset x position.
- `Y_INIT`, 40: reset y position.
- `CURSOR_COLOR`, 5: palette index driven while the cursor is hit.

Ports:
- `clk`, in, 1: pixel/system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `up`, `down`, `left`, `right`, in, 1 each: buttons, active-low, asynchronous to clk.
- `row`, in, 9: current scan row.
- `col`, in, 10: current scan column.
- `cursor_here`, out, 1: the scan pixel is inside the cursor.
- `color_index`, out, 8: `CURSOR_COLOR` when `cursor_here` is high, else 0.
- `x`, out, 10: cursor top-left column.
- `y`, out, 9: cursor top-left row.
- `moved`, out, 1: one-cycle pulse on every cycle that `x` or `y` changes.

## Operation

- **Button sync:** each button passes through a 2-flop synchroniser, then is inverted to an active-high `held[3:0]`.
- **Direction vector:**
  - dx = right − left; if both are held, dx = 0.
  - dy = down − up; if both are held, dy = 0.
  - A press is "active" when dx ≠ 0 or dy ≠ 0.
- **Tick counter:** counts 0..TICK_DIV−1 and wraps. `tick` is asserted on the cycle the count equals TICK_DIV−1. All movement decisions happen only on `tick`.
- **Movement FSM** (on `tick`):
  - IDLE: if active → move, clear hold_cnt, go to HOLD.
  - HOLD:
    - not active → IDLE.
    - direction vector differs from the one latched at the last move → move, clear hold_cnt, stay in HOLD.
    - otherwise increment hold_cnt; when it reaches REPEAT_DELAY → move, go to REPEAT.
  - REPEAT:
    - not active → IDLE.
    - direction change → move, clear hold_cnt, go to HOLD.
    - otherwise → move.
- **Move:**
  - x ← clamp(x + dx·STEP, 0, SCREEN_W − CURSOR_SIZE); y is clamped the same way against SCREEN_H.
  - Compute in signed 12-bit arithmetic so there is no wrap-around below 0.
  - A move that leaves both coordinates unchanged (already at the clamp) does not pulse `moved`.
- **Hit test:**
  - Condition: x ≤ col < x + CURSOR_SIZE and y ≤ row < y + CURSOR_SIZE. Both bounds are inclusive on the low edge and exclusive on the high edge.
  - Compare in 11-bit arithmetic.
  - The result is registered into `cursor_here` / `color_index`.

## Timing

- **Reset values:**
  - x = X_INIT, y = Y_INIT.
  - cursor_here = 0, color_index = 0, moved = 0.
  - FSM = IDLE, tick counter = 0, hold_cnt = 0, synchronisers = all-ones (released).
- **Button latency:** a button edge is visible to the FSM 2 cycles after it is sampled. A move takes effect at the next `tick`; `x`/`y`/`moved` update on the clock edge at the end of the tick cycle.
- **Hit latency:** 1 cycle from `row`/`col` to `cursor_here`. The compare uses the current (pre-update) `x`/`y`.
- **Reset mid-move or mid-hold:** the position returns to X_INIT/Y_INIT immediately (asynchronously). The FSM restarts in IDLE; a button still held after reset causes a move on the first tick.
- **Repeat sequence:** a constant hold produces moves at tick 0, then tick REPEAT_DELAY, then every tick after that.

## Structure

- **Package `cursor_pkg`:**
  - FSM state enum (IDLE, HOLD, REPEAT).
  - Direction index constants (DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3).
  - A clamp helper function.
- **Sub-module `btn_sync`:** a parameterised-width 2-flop synchroniser with a set-on-reset value, instantiated once for the 4 buttons.
- **Top level:** the tick divider, FSM, position registers and hit test.

## Test plan

Bench parameters: TICK_DIV=4, REPEAT_DELAY=2, STEP=10, CURSOR_SIZE=10.

- **Reset, no buttons:** x=120, y=40, moved=0. Probe row=45, col=125 → cursor_here=1 and color_index=5 one cycle later. Probe col=130 → cursor_here=0.
- **Right held continuously:** moves at the 1st, 3rd, 4th and 5th ticks, giving x=130, 140, 150, 160. `moved` pulses exactly 4 times.
- **Left held from x=120:** x reaches 0 after 12 moves and stays there; no further `moved` pulses. Right held from 620 → x stays at 630 (the clamp).
- **Up+left together:** diagonal move (110, 30). Adding down while up+left is still held → dy=0, direction change, immediate move to x=100 with y=30 unchanged.
- **Left+right together:** no movement and no `moved` pulse.
- **Reset asserted during REPEAT at x=160:** outputs return to reset values asynchronously. With right still held after release, x=130 on the first tick.
